count_seq_checker: RTL and testbench

COUNT_SEQ_CHECKER -- requirements
Module: count_seq_checker

---
 rtl/count_chk_pkg.sv | 10 +
 rtl/count_seq_checker_if.sv | 17 +
 rtl/count_seq_checker_sat_counter.sv | 16 +
 rtl/count_seq_checker.sv | 85 ++++++++
 tb/tb_count_seq_checker.sv | 133 +++++++++++++
 5 files changed

// File: rtl/count_chk_pkg.sv
// Shared types and helpers for the count sequence checker.
package count_chk_pkg;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] v);
      return v + 1'b1;
   endfunction
endpackage

// File: rtl/count_seq_checker_if.sv
// Upstream count stream in, checker status out.
interface count_seq_checker_if #(parameter int ERR_W = 8);
   import count_chk_pkg::*;

   logic [CNT_W-1:0] count_in;
   logic             valid;
   logic             clr_err;
   logic             wrap;
   logic             seq_err;
   logic             locked;
   logic [ERR_W-1:0] err_cnt;

   modport master (output count_in, valid, clr_err,
                   input  wrap, seq_err, locked, err_cnt);
   modport slave  (input  count_in, valid, clr_err,
                   output wrap, seq_err, locked, err_cnt);
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/count_seq_checker.sv
// Verifies a 3-bit free-running count stream, flags illegal steps and locks after LOCK_N good steps.
// Define COUNT_SEQ_CHECKER_HOLD_EN to accept a repeated value as a legal (neutral) step.
module count_seq_checker
   import count_chk_pkg::*;
#(
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   count_seq_checker_if.slave bus
);
   state_t           state, state_nx;
   logic [CNT_W-1:0] prev, prev_nx;
   logic [3:0]       good, good_nx;
   logic             wrap_q, wrap_nx;
   logic             err_q, err_nx;
   logic             step_ok, rpt;

   always_comb begin
      state_nx = state;
      prev_nx  = prev;
      good_nx  = good;
      wrap_nx  = 1'b0;
      err_nx   = 1'b0;
      step_ok  = (bus.count_in == next_cnt(prev));
`ifdef COUNT_SEQ_CHECKER_HOLD_EN
      rpt      = (bus.count_in == prev);
`else
      rpt      = 1'b0;
`endif
      if (bus.valid) begin
         prev_nx = bus.count_in;
         case (state)
            IDLE: begin
               state_nx = ACQUIRE;
               good_nx  = '0;
            end
            ACQUIRE, LOCKED: begin
               if (step_ok) begin
                  // a legal step landing on 0 can only have come from 7
                  wrap_nx = (bus.count_in == '0);
                  if (state == ACQUIRE) begin
                     good_nx = good + 4'd1;
                     if (good_nx == 4'(LOCK_N)) state_nx = LOCKED;
                  end
               end else if (!rpt) begin
                  err_nx   = 1'b1;
                  good_nx  = '0;
                  state_nx = ACQUIRE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         prev   <= '0;
         good   <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         prev   <= prev_nx;
         good   <= good_nx;
         wrap_q <= wrap_nx;
         err_q  <= err_nx;
      end
   end

   sat_counter #(.W(ERR_W)) u_err (
      .clk   (clk),
      .reset (reset),
      .inc   (err_nx),
      .clr   (bus.clr_err),
      .cnt   (bus.err_cnt)
   );

   assign bus.wrap    = wrap_q;
   assign bus.seq_err = err_q;
   assign bus.locked  = (state == LOCKED);
endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench: default checker plus a 2-bit error counter instance on the same stream.
module tb_count_seq_checker;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       valid = 1'b0;
   logic       clr = 1'b0;
   logic [2:0] cnt = 3'd0;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   count_seq_checker_if #(.ERR_W(8)) if_a ();
   count_seq_checker_if #(.ERR_W(2)) if_b ();

   assign if_a.count_in = cnt;
   assign if_a.valid    = valid;
   assign if_a.clr_err  = clr;
   assign if_b.count_in = cnt;
   assign if_b.valid    = valid;
   assign if_b.clr_err  = clr;

   count_seq_checker #(.LOCK_N(4), .ERR_W(8)) u_dut (.clk(clk), .reset(reset), .bus(if_a));
   count_seq_checker #(.LOCK_N(4), .ERR_W(2)) u_sat (.clk(clk), .reset(reset), .bus(if_b));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic v, input logic [2:0] c, input logic cl);
      valid = v;
      cnt   = c;
      clr   = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input int w, input int e, input int l);
      chk({tag, ".wrap"},    32'(if_a.wrap),    32'(w));
      chk({tag, ".seq_err"}, 32'(if_a.seq_err), 32'(e));
      chk({tag, ".locked"},  32'(if_a.locked),  32'(l));
   endtask

   initial begin
      // reset state
      #2 reset = 1'b0;
      #1;
      chk_out("rst_async", 0, 0, 0);
      chk("rst_async.err", 32'(if_a.err_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      chk_out("rst_held", 0, 0, 0);
      chk("rst_held.err", 32'(if_a.err_cnt), 0);
      reset = 1'b1;

      // 0..4 locks after the sample of 4
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 3'(i), 1'b0);
         chk_out($sformatf("acq%0d", i), 0, 0, (i == 4) ? 1 : 0);
      end

      // 5,6,7,0 while locked: single wrap after the 0
      step(1'b1, 3'd5, 1'b0); chk_out("lk5", 0, 0, 1);
      step(1'b1, 3'd6, 1'b0); chk_out("lk6", 0, 0, 1);
      step(1'b1, 3'd7, 1'b0); chk_out("lk7", 0, 0, 1);
      step(1'b1, 3'd0, 1'b0); chk_out("lk0", 1, 0, 1);
      step(1'b0, 3'd3, 1'b0); chk_out("gap", 0, 0, 1);
      step(1'b1, 3'd1, 1'b0); chk_out("lk1", 0, 0, 1);

      // illegal 1->5 unlocks, then relock on 6,7,0,1
      step(1'b1, 3'd5, 1'b0); chk_out("bad5", 0, 1, 0);
      chk("bad5.err", 32'(if_a.err_cnt), 1);
      step(1'b1, 3'd6, 1'b0); chk_out("re6", 0, 0, 0);
      step(1'b1, 3'd7, 1'b0); chk_out("re7", 0, 0, 0);
      step(1'b1, 3'd0, 1'b0); chk_out("re0", 1, 0, 0);
      step(1'b1, 3'd1, 1'b0); chk_out("re1", 0, 0, 1);

      // five illegal steps: 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 3'(3 + 2 * i), 1'b0);
         chk($sformatf("sat%0d.seq_err", i), 32'(if_b.seq_err), 1);
         chk($sformatf("sat%0d.err_b", i), 32'(if_b.err_cnt), (i == 0) ? 2 : 3);
      end
      chk("sat.err_a", 32'(if_a.err_cnt), 6);
      step(1'b1, 3'd5, 1'b1);
      chk("clr.seq_err", 32'(if_a.seq_err), 1);
      chk("clr.err_a", 32'(if_a.err_cnt), 0);
      chk("clr.err_b", 32'(if_b.err_cnt), 0);
      step(1'b1, 3'd6, 1'b0);
      chk("post_clr.seq_err", 32'(if_a.seq_err), 0);
      chk("post_clr.err_a", 32'(if_a.err_cnt), 0);

      // repeated value 3,3
      step(1'b1, 3'd7, 1'b0); chk_out("pre_rpt", 0, 0, 0);
      step(1'b1, 3'd3, 1'b0); chk_out("rpt_a", 0, 1, 0);
      step(1'b1, 3'd3, 1'b0);
`ifdef COUNT_SEQ_CHECKER_HOLD_EN
      chk_out("rpt_b", 0, 0, 0);
      chk("rpt_b.err", 32'(if_a.err_cnt), 1);
`else
      chk_out("rpt_b", 0, 1, 0);
      chk("rpt_b.err", 32'(if_a.err_cnt), 2);
`endif

      // lock again, then async reset between edges
      step(1'b1, 3'd4, 1'b0);
      step(1'b1, 3'd5, 1'b0);
      step(1'b1, 3'd6, 1'b0);
      step(1'b1, 3'd7, 1'b0); chk_out("lk_again", 0, 0, 1);
      step(1'b1, 3'd0, 1'b0); chk_out("lk_wrap", 1, 0, 1);
      valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk_out("mid_rst", 0, 0, 0);
      chk("mid_rst.err_a", 32'(if_a.err_cnt), 0);
      chk("mid_rst.err_b", 32'(if_b.err_cnt), 0);
      reset = 1'b1;
      step(1'b0, 3'd2, 1'b0); chk_out("rel_gap0", 0, 0, 0);
      step(1'b0, 3'd6, 1'b0); chk_out("rel_gap1", 0, 0, 0);
      step(1'b1, 3'd5, 1'b0); chk_out("idle_cap", 0, 0, 0);
      chk("idle_cap.err", 32'(if_a.err_cnt), 0);
      step(1'b1, 3'd2, 1'b0); chk_out("restart_bad", 0, 1, 0);
      chk("restart_bad.err", 32'(if_a.err_cnt), 1);
      step(1'b0, 3'd0, 1'b0); chk_out("end_gap", 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
